// File: rtl/keypad_msg_tx_pkg.sv
// rtl/keypad_msg_tx_pkg.sv - shared state enum, key codes and keypad map
// Digits use their own value as key code; letters and symbols take 10..15.
package keypad_msg_tx_pkg;

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'd0;
    case ({row, col})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = KEY_A;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = KEY_B;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'd0;
      4'hE: code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_msg_tx_if.sv
// rtl/keypad_msg_tx_if.sv - byte/strobe handshake towards the UART transmitter
interface keypad_msg_tx_if;
  logic [7:0] data_send;
  logic       tx_ctrl;
  logic       transmit_ready;

  modport master (output data_send, output tx_ctrl, input transmit_ready);
  modport slave  (input data_send, input tx_ctrl, output transmit_ready);
endinterface

// File: rtl/keypad_msg_tx_scanner.sv
// rtl/keypad_msg_tx_scanner.sv - column rotation, row decode and press/release detection
// A press fires once; release needs SCAN_IDLE_SCANS sweeps' worth of consecutive idle cycles.
module keypad_scanner
  import keypad_msg_tx_pkg::*;
#(
  parameter int SCAN_IDLE_SCANS = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] i_readrow,
  output logic [3:0] o_scancol,
  output logic       o_key_valid,
  output logic [3:0] o_key_code
);

  localparam int IDLE_CYCLES = 4 * SCAN_IDLE_SCANS;
  localparam int CW = $clog2(IDLE_CYCLES + 1);

  logic [3:0]    r_col;
  logic          r_held;
  logic [CW-1:0] r_idle_cnt;
  logic [1:0]    w_row;
  logic [1:0]    w_col;
  logic          w_hit;

  always_comb begin
    w_row = 2'd0;
    if      (i_readrow[0]) w_row = 2'd0;
    else if (i_readrow[1]) w_row = 2'd1;
    else if (i_readrow[2]) w_row = 2'd2;
    else if (i_readrow[3]) w_row = 2'd3;
    w_col = 2'd0;
    case (r_col)
      4'b0010: w_col = 2'd1;
      4'b0100: w_col = 2'd2;
      4'b1000: w_col = 2'd3;
      default: w_col = 2'd0;
    endcase
  end

  assign w_hit = |i_readrow;

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_col      <= 4'b0001;
      r_held     <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      r_col <= {r_col[2:0], r_col[3]};
      if (w_hit) begin
        r_held     <= 1'b1;
        r_idle_cnt <= '0;
      end else if (r_held) begin
        if (r_idle_cnt == CW'(IDLE_CYCLES - 1)) begin
          r_held     <= 1'b0;
          r_idle_cnt <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + CW'(1);
        end
      end
    end
  end

  assign o_scancol   = r_col;
  assign o_key_valid = w_hit & ~r_held;
  assign o_key_code  = key_lookup(w_row, w_col);

endmodule

// File: rtl/keypad_msg_tx.sv
// rtl/keypad_msg_tx.sv - keypad message editor with byte-wise send to the UART transmitter
// Digits are staged as pending, committed with C, and the whole buffer is sent on D.
module keypad_msg_tx
  import keypad_msg_tx_pkg::*;
#(
  parameter int MSG_BYTES       = 16,
  parameter int SCAN_IDLE_SCANS = 1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [3:0]             readrow,
  output logic [3:0]             scancol,
  keypad_msg_tx_if.master        tx
);

  localparam int CNT_W = $clog2(MSG_BYTES + 1);
  localparam int IDX_W = $clog2(MSG_BYTES);

  logic [7:0]       r_buf [MSG_BYTES];
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_idx;
  logic [7:0]       r_pending;
  logic             r_pending_valid;
  logic             r_armed;
  logic [7:0]       r_data_send;
  logic             r_tx_ctrl;
  state_t           r_state;
  logic             w_key_valid;
  logic [3:0]       w_key_code;

  keypad_scanner #(.SCAN_IDLE_SCANS(SCAN_IDLE_SCANS)) u_scanner (
    .clk         (clk),
    .nrst        (nrst),
    .i_readrow   (readrow),
    .o_scancol   (scancol),
    .o_key_valid (w_key_valid),
    .o_key_code  (w_key_code)
  );

  always_ff @(posedge clk) begin
    if (nrst) begin
      for (int i = 0; i < MSG_BYTES; i++) r_buf[i] <= 8'h00;
      r_count         <= '0;
      r_idx           <= '0;
      r_pending       <= 8'h00;
      r_pending_valid <= 1'b0;
      r_armed         <= 1'b0;
      r_data_send     <= 8'h00;
      r_tx_ctrl       <= 1'b0;
      r_state         <= IDLE;
    end else begin
      r_tx_ctrl <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_key_valid) begin
            if (w_key_code <= 4'd9) begin
              r_pending       <= ASCII_ZERO + {4'd0, w_key_code};
              r_pending_valid <= 1'b1;
            end else begin
              case (w_key_code)
                KEY_C: if (r_pending_valid && (r_count < CNT_W'(MSG_BYTES))) begin
                  r_buf[r_count[IDX_W-1:0]] <= r_pending;
                  r_count                   <= r_count + CNT_W'(1);
                  r_pending_valid           <= 1'b0;
                end
                KEY_STAR: if (r_count != '0) r_count <= r_count - CNT_W'(1);
                KEY_HASH: begin
                  r_count         <= '0;
                  r_pending_valid <= 1'b0;
                end
                KEY_D: if (r_count != '0) begin
                  r_state <= SEND;
                  r_idx   <= '0;
                  r_armed <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        SEND: begin
          // One byte per ready level: re-arm only after the transmitter reports busy.
          if (r_armed && tx.transmit_ready) begin
            r_data_send <= r_buf[r_idx[IDX_W-1:0]];
            r_tx_ctrl   <= 1'b1;
            r_armed     <= 1'b0;
            r_idx       <= r_idx + CNT_W'(1);
            if (r_idx == r_count - CNT_W'(1)) begin
              r_state         <= IDLE;
              r_count         <= '0;
              r_pending_valid <= 1'b0;
            end
          end else if (!tx.transmit_ready) begin
            r_armed <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx.data_send = r_data_send;
  assign tx.tx_ctrl   = r_tx_ctrl;

endmodule

// File: tb/tb_keypad_msg_tx.sv
// tb/tb_keypad_msg_tx.sv - directed self-checking bench for keypad_msg_tx
module tb_keypad_msg_tx;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic [3:0] readrow = 4'd0;
  logic [3:0] scancol;
  logic       auto_ready = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] got[$];
  logic [3:0] exp_cols[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  string      km[4] = '{"123A", "456B", "789C", "*0#D"};

  keypad_msg_tx_if tx_bus ();

  keypad_msg_tx dut (
    .clk     (clk),
    .nrst    (nrst),
    .readrow (readrow),
    .scancol (scancol),
    .tx      (tx_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one cycle, log strobes, and optionally emulate a transmitter busy for one cycle per byte.
  task automatic tick();
    @(posedge clk);
    #1;
    if (tx_bus.tx_ctrl) begin
      got.push_back(tx_bus.data_send);
      if (auto_ready) tx_bus.transmit_ready = 1'b0;
    end else if (auto_ready && !tx_bus.transmit_ready) begin
      tx_bus.transmit_ready = 1'b1;
    end
  endtask

  task automatic press(input byte k, input int hold = 1);
    int row = -1;
    int col = 0;
    int w = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (km[r][c] == k) begin
          row = r;
          col = c;
        end
    if (row < 0) check("key_lookup", 32'(k), 32'hFFFF);
    else begin
      while (!scancol[col] && w < 8) begin
        tick();
        w++;
      end
      if (w >= 8) check("scan_align", 32'(w), 32'd0);
      readrow = 4'(1 << row);
      repeat (hold) tick();
      readrow = 4'd0;
      repeat (10) tick();
    end
  endtask

  task automatic commit(input string s);
    for (int i = 0; i < s.len(); i++) begin
      press(s[i]);
      press("C");
    end
  endtask

  task automatic check_msg(input string tag, input string exp);
    logic [7:0] v;
    check({tag, "_len"}, 32'(got.size()), 32'(exp.len()));
    for (int i = 0; i < exp.len(); i++) begin
      v = (i < got.size()) ? got[i] : 8'hxx;
      check(tag, 32'(v), 32'(exp[i]));
    end
  endtask

  initial begin
    tx_bus.transmit_ready = 1'b1;
    repeat (3) tick();
    check("rst_scancol", 32'(scancol), 32'h1);
    check("rst_tx_ctrl", 32'(tx_bus.tx_ctrl), 32'h0);
    check("rst_data_send", 32'(tx_bus.data_send), 32'h0);
    nrst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("scan_rotate", 32'(scancol), 32'(exp_cols[i]));
    end

    auto_ready = 1'b1;
    got.delete();
    commit("911");
    press("D");
    repeat (40) tick();
    check_msg("msg_911", "911");
    got.delete();
    press("D");
    repeat (20) tick();
    check("after_911_idle", 32'(got.size()), 32'd0);

    auto_ready = 1'b0;
    tx_bus.transmit_ready = 1'b1;
    got.delete();
    commit("12");
    press("D");
    repeat (20) tick();
    check_msg("stall_one", "1");
    tx_bus.transmit_ready = 1'b0;
    repeat (10) tick();
    check("stall_low", 32'(got.size()), 32'd1);
    tx_bus.transmit_ready = 1'b1;
    tick();
    check("stall_rise_strobe", 32'(tx_bus.tx_ctrl), 32'd1);
    check("stall_rise_data", 32'(tx_bus.data_send), 32'h32);
    repeat (10) tick();
    check_msg("stall_all", "12");

    auto_ready = 1'b1;
    got.delete();
    press("7");
    press("C", 20);
    press("D");
    repeat (30) tick();
    check_msg("hold_one_event", "7");

    got.delete();
    press("D");
    repeat (10) tick();
    press("4");
    press("D");
    repeat (20) tick();
    check("d_empty_or_uncommitted", 32'(got.size()), 32'd0);
    press("#");

    got.delete();
    for (int i = 0; i < 17; i++) begin
      press(byte'(8'h30 + i % 10));
      press("C");
    end
    press("D");
    repeat (80) tick();
    check_msg("overflow", "0123456789012345");

    got.delete();
    commit("12");
    press("*");
    press("D");
    repeat (20) tick();
    check_msg("backspace", "1");

    got.delete();
    commit("1");
    press("#");
    press("D");
    repeat (20) tick();
    check("hash_clear", 32'(got.size()), 32'd0);

    auto_ready = 1'b0;
    tx_bus.transmit_ready = 1'b1;
    got.delete();
    commit("123");
    press("D");
    repeat (5) tick();
    check_msg("rst_first", "1");
    tx_bus.transmit_ready = 1'b0;
    tick();
    tx_bus.transmit_ready = 1'b1;
    nrst = 1'b1;
    tick();
    check("rst_abort_strobe", 32'(tx_bus.tx_ctrl), 32'd0);
    nrst = 1'b0;
    tx_bus.transmit_ready = 1'b0;
    tick();
    tx_bus.transmit_ready = 1'b1;
    repeat (10) tick();
    press("D");
    repeat (20) tick();
    check("rst_no_more", 32'(got.size()), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
